// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter:
// FSM state encoding and parameter defaults.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2
  } arb_state_t;

  localparam int unsigned BUS_WIDTH_DEF    = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one shared memory port.
// Data wins by default; fetch is forced through after STARVE_LIMIT data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = BUS_WIDTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [DATA_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  input  logic                    dm_rd,
  input  logic                    dm_wr,
  input  logic [DATA_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_byte_mark,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_valid,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    if_stall,
  output logic                    dm_stall
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             dm_any;
  logic             take_dm;
  logic             take_if;
  logic             flush_seen;

  always_comb begin
    dm_any     = dm_rd | dm_wr;
    starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
    take_dm    = (state == IDLE) && dm_any && !(if_req && starve_hit);
    take_if    = (state == IDLE) && if_req && !take_dm;
  end

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_any & ~dm_valid;

  // Counts data grants taken while a fetch is waiting; any idle fetch side clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req || take_if) begin
      starve_cnt <= '0;
    end else if (take_dm && !starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      flush_seen <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (take_dm) begin
            state     <= GRANT_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_wr;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_wr ? dm_byte_mark : '1;
          end else if (take_if) begin
            state      <= GRANT_IF;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_be     <= '1;
            flush_seen <= 1'b0;
          end
        end
        GRANT_IF: begin
          if (if_flush) flush_seen <= 1'b1;
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= ~(flush_seen | if_flush);
          end
        end
        GRANT_DM: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            dm_valid <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
